// File: rtl/async_fifo_gen.sv
// Dual-clock FIFO: Gray pointer crossing, fill levels, almost and sticky error flags.
// Define AFIFO_FWFT_EN for a first-word-fall-through read port.
module async_fifo_gen #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5,
  parameter int AF_THRESH     = 2,
  parameter int AE_THRESH     = 2
) (
  input  logic                   RClk,
  input  logic                   PresetFull,
  input  logic                   WClk,
  input  logic [DATA_WIDTH-1:0]  Data_in,
  input  logic                   WriteEn_in,
  output logic                   Full_out,
  output logic                   Almost_full_out,
  output logic [ADDRESS_WIDTH:0] Wr_level_out,
  output logic                   Overflow_out,
  input  logic                   ReadEn_in,
  output logic [DATA_WIDTH-1:0]  Data_out,
  output logic                   Empty_out,
  output logic                   Almost_empty_out,
  output logic [ADDRESS_WIDTH:0] Rd_level_out,
  output logic                   Underflow_out
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int FIFO_DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_W = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_W = (AW+1)'(AE_THRESH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [1:0] wrst_q, rrst_q;
  logic       wrst, rrst;

  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) wrst_q <= 2'b11;
    else            wrst_q <= {wrst_q[0], 1'b0};
  end

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) rrst_q <= 2'b11;
    else            rrst_q <= {rrst_q[0], 1'b0};
  end

  assign wrst = wrst_q[1];
  assign rrst = rrst_q[1];

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Write domain
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [AW:0] rq1_q, rq2_q, wlvl_q, wlvl_d;
  logic        full_q, full_d, afull_q, afull_d, ovf_q, wr_ok;
  logic [AW:0] rgray_q;

  always_comb begin
    wr_ok   = WriteEn_in & ~full_q;
    wbin_d  = wbin_q + {{AW{1'b0}}, wr_ok};
    wgray_d = bin2gray(wbin_d);
    full_d  = wgray_d == {~rq2_q[AW:AW-1], rq2_q[AW-2:0]};
    wlvl_d  = wbin_d - gray2bin(rq2_q);
    afull_d = (DEPTH_W - wlvl_d) <= AF_W;
  end

  always_ff @(posedge WClk) begin
    if (wr_ok) mem_q[wbin_q[AW-1:0]] <= Data_in;
  end

  always_ff @(posedge WClk or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      wlvl_q  <= '0;
      full_q  <= 1'b1;
      afull_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rgray_q;
      rq2_q   <= rq1_q;
      wlvl_q  <= wlvl_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_q | (WriteEn_in & full_q);
    end
  end

  // Read domain
  logic [AW:0]           rbin_q, rbin_d, rcons_d;
  logic [AW:0]           wq1_q, wq2_q, rlvl_q, rlvl_d;
  logic                  empty_q, empty_d, aempty_q, aempty_d;
  logic                  udf_q, rd_ok;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
`ifdef AFIFO_FWFT_EN
  logic                  valid_q, valid_d;
`endif

  always_comb begin
    dout_d = dout_q;
`ifdef AFIFO_FWFT_EN
    rd_ok   = ~empty_q & (~valid_q | ReadEn_in);
    valid_d = rd_ok | (valid_q & ~ReadEn_in);
    if (rd_ok) dout_d = mem_q[rbin_q[AW-1:0]];
    rbin_d  = rbin_q + {{AW{1'b0}}, rd_ok};
    // Slot of the prefetched word stays owned until it is acknowledged
    rcons_d = rbin_d - {{AW{1'b0}}, valid_d};
`else
    rd_ok   = ReadEn_in & ~empty_q;
    if (rd_ok) dout_d = mem_q[rbin_q[AW-1:0]];
    rbin_d  = rbin_q + {{AW{1'b0}}, rd_ok};
    rcons_d = rbin_d;
`endif
    empty_d  = bin2gray(rbin_d) == wq2_q;
    rlvl_d   = gray2bin(wq2_q) - rcons_d;
    aempty_d = rlvl_d <= AE_W;
  end

  always_ff @(posedge RClk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      wq1_q    <= '0;
      wq2_q    <= '0;
      rlvl_q   <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      udf_q    <= 1'b0;
      dout_q   <= '0;
`ifdef AFIFO_FWFT_EN
      valid_q  <= 1'b0;
`endif
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= bin2gray(rcons_d);
      wq1_q    <= wgray_q;
      wq2_q    <= wq1_q;
      rlvl_q   <= rlvl_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      udf_q    <= udf_q | (ReadEn_in & Empty_out);
      dout_q   <= dout_d;
`ifdef AFIFO_FWFT_EN
      valid_q  <= valid_d;
`endif
    end
  end

  assign Full_out         = full_q;
  assign Almost_full_out  = afull_q;
  assign Wr_level_out     = wlvl_q;
  assign Overflow_out     = ovf_q;
  assign Data_out         = dout_q;
  assign Almost_empty_out = aempty_q;
  assign Rd_level_out     = rlvl_q;
  assign Underflow_out    = udf_q;
`ifdef AFIFO_FWFT_EN
  assign Empty_out        = ~valid_q;
`else
  assign Empty_out        = empty_q;
`endif

endmodule

// File: doc/async_fifo_gen.md
# async_fifo_gen

Parametrised dual-clock FIFO, the next generation of the team's asynchronous FIFO. Gray-coded pointers cross domains through 2-flop synchronisers, with no async status latch. Adds per-domain fill levels, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and an optional first-word-fall-through read port. Sits between ADC/DAC sample domains and the controller fabric clock wherever a clock-domain crossing with flow control is needed.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDRESS_WIDTH, 5, log2 of depth; must be ≥ 2.
- FIFO_DEPTH, 1 << ADDRESS_WIDTH, storage words. Fixed by ADDRESS_WIDTH; not independently settable.
- AF_THRESH, 2, Almost_full_out asserts when free words ≤ AF_THRESH.
- AE_THRESH, 2, Almost_empty_out asserts when stored words ≤ AE_THRESH.

Ports:
- RClk  in  1  read clock; primary clock of the block.
- PresetFull  in  1  reset; asynchronous, active-high. Resets both domains.
- WClk  in  1  write clock.
- Data_in  in  DATA_WIDTH  write data.
- WriteEn_in  in  1  write request.
- Full_out  out  1  no free word; writes are ignored.
- Almost_full_out  out  1  free words ≤ AF_THRESH.
- Wr_level_out  out  ADDRESS_WIDTH+1  stored-word count as seen from the write domain.
- Overflow_out  out  1  sticky; set by a write attempted while full.
- ReadEn_in  in  1  read request.
- Data_out  out  DATA_WIDTH  read data.
- Empty_out  out  1  no readable word.
- Almost_empty_out  out  1  stored words ≤ AE_THRESH.
- Rd_level_out  out  ADDRESS_WIDTH+1  stored-word count as seen from the read domain.
- Underflow_out  out  1  sticky; set by a read attempted while empty.

## Operation
- Reset handling:
  - PresetFull asserts asynchronously in both domains.
  - Deassertion is synchronised separately per domain through a 2-flop reset synchroniser.
- Pointers:
  - Binary and Gray write/read pointers, each ADDRESS_WIDTH+1 bits; the extra MSB is the wrap bit.
  - Pointers wrap naturally modulo 2·FIFO_DEPTH.
- Write:
  - A write occurs when WriteEn_in & ~Full_out at the WClk edge.
  - Mem[wr_bin[ADDRESS_WIDTH-1:0]] ← Data_in, then the write pointer increments.
- Read (standard mode):
  - A read occurs when ReadEn_in & ~Empty_out at the RClk edge.
  - Data_out ← Mem[rd addr]; Data_out holds its value otherwise.
- Crossing: each Gray pointer passes through two flops clocked by the opposite domain's clock.
- Full and empty detection:
  - Full_out: next write Gray pointer == synchronised read Gray pointer with its top two bits inverted. Registered.
  - Empty_out: next read Gray pointer == synchronised write Gray pointer. Registered.
- Levels:
  - Wr_level_out = wr_bin − gray2bin(sync rd_gray).
  - Rd_level_out = gray2bin(sync wr_gray) − rd_bin.
  - Both are unsigned modulo 2^(ADDRESS_WIDTH+1), registered, and range 0..FIFO_DEPTH.
- Almost flags:
  - Almost_full_out = (FIFO_DEPTH − Wr_level_out) ≤ AF_THRESH.
  - Almost_empty_out = Rd_level_out ≤ AE_THRESH.
- Error flags:
  - Overflow_out sets on WriteEn_in & Full_out.
  - Underflow_out sets on ReadEn_in & Empty_out.
  - Both clear only on PresetFull.
  - The offending access has no effect on pointers or memory.
- Flag pessimism: flags are conservative; Full and Empty may deassert late, but never early.

## Timing
- Reset values (while PresetFull is high):
  - Full_out=1, Almost_full_out=1.
  - Empty_out=1, Almost_empty_out=1.
  - Levels=0, Overflow_out=0, Underflow_out=0.
  - Data_out=0.
- After reset deassertion: Full_out and Almost_full_out drop 2–3 WClk edges later; Almost_empty_out stays 1.
- Write to read side: a write at WClk edge N deasserts Empty_out after 2 sync flops plus 1 flag register, i.e. on the 3rd RClk edge (≤ 3 edges, +1 for metastability resolution).
- Read to write side: a read frees a slot, and Full_out deasserts within 3 WClk edges.
- Read data latency: 1 RClk edge from an accepted read (standard mode).
- Full assertion is immediate: the write that fills the last word sets Full_out on the same edge, so a back-to-back write is refused.
- Empty assertion is immediate: the read of the last word sets Empty_out on the same edge.
- Simultaneous read and write on one word: both are legal; memory is a true dual-port array.
- Wrap-around: continuous traffic through 2·FIFO_DEPTH words must show no flag glitches.
- Reset mid-operation: contents are discarded, pointers return to 0 and flags return to their reset values.

## Configuration
- AFIFO_FWFT_EN defined (first-word-fall-through read port):
  - Data_out is driven from a prefetch output register.
  - Empty_out=0 means Data_out already holds valid data.
  - ReadEn_in acknowledges that word and advances; the next word appears on the following RClk edge.
  - Rd_level_out includes the prefetched word.
  - Empty deassert latency grows by 1 RClk edge.
- AFIFO_FWFT_EN undefined: standard registered read as above.

## Test plan
- Reset, then 32 writes with a stalled reader (ADDRESS_WIDTH=5, WClk 100 MHz, RClk 77 MHz) -> Full_out=1 after the 32nd write; a 33rd write sets Overflow_out=1 and Mem is unchanged.
- Read 32 words from the full FIFO -> data 0..31 in order; Empty_out=1 after the last read; one extra read sets Underflow_out=1.
- A single write of 0xA5A5 into the empty FIFO -> Empty_out deasserts ≤ 3 RClk edges later; with FWFT, Data_out=0xA5A5 while Empty_out=0.
- Thresholds with AF=2, AE=2 -> Almost_full_out=1 at Wr_level_out=30; Almost_empty_out=0 at Rd_level_out=3.
- 10 000 random-enable transfers at ratios 1:3 and 3:1 -> scoreboard shows no loss, duplication or reordering, and levels stay within 0..32.
- PresetFull pulsed mid-burst -> all outputs return to reset values; the post-release sequence 0,1,2 is read back correctly.
